// File: rtl/mux_arbiter.sv
// Two-requester arbiter driving a shared channel: round-robin on ties,
// bursts capped at MAX_BURST accepted beats while the other side waits.
module mux_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req1,
  input  logic              req2,
  input  logic [DATA_W-1:0] IN1,
  input  logic [DATA_W-1:0] IN2,
  input  logic              out_ready,
  output logic              gnt1,
  output logic              gnt2,
  output logic              sel,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              ack1,
  output logic              ack2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  // 0: requester 1 served last, 1: requester 2 served last
  logic       last_served, last_nxt;
  logic       beat;

  assign gnt1      = (state == GNT1);
  assign gnt2      = (state == GNT2);
  assign sel       = gnt2;
  assign out       = sel ? IN2 : IN1;
  assign out_valid = (gnt1 & req1) | (gnt2 & req2);
  assign beat      = out_valid & out_ready;
  assign ack1      = beat & gnt1;
  assign ack2      = beat & gnt2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      last_served <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      last_served <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last_served;
    case (state)
      IDLE: begin
        if (req1 && (!req2 || last_served)) begin
          state_nxt = GNT1;
          cnt_nxt   = 8'd0;
          last_nxt  = 1'b0;
        end else if (req2) begin
          state_nxt = GNT2;
          cnt_nxt   = 8'd0;
          last_nxt  = 1'b1;
        end
      end
      GNT1: begin
        // An owner drop takes priority; it also means no beat this cycle.
        if (!req1) begin
          cnt_nxt = 8'd0;
          if (req2) begin
            state_nxt = GNT2;
            last_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (beat) begin
          if (cnt == BURST_LAST) begin
            cnt_nxt = 8'd0;
            if (req2) begin
              state_nxt = GNT2;
              last_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      GNT2: begin
        if (!req2) begin
          cnt_nxt = 8'd0;
          if (req1) begin
            state_nxt = GNT1;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (beat) begin
          if (cnt == BURST_LAST) begin
            cnt_nxt = 8'd0;
            if (req1) begin
              state_nxt = GNT1;
              last_nxt  = 1'b0;
            end
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Drives two arbiters (bursts of 4 and 1) from shared inputs and compares
// every output each cycle against an ownership/beat-count reference model.
module tb_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst, req1, req2, out_ready;
  logic [7:0] in1, in2;
  logic [1:0] gnt1_o, gnt2_o, sel_o, ov_o, ack1_o, ack2_o;
  logic [7:0] out_o [2];

  int errors = 0;
  int checks = 0;

  // reference model: who owns the channel, beats taken in this burst, who was served last
  int m_owner [2];
  int m_cnt   [2];
  int m_last  [2];
  int mb      [2] = '{4, 1};

  always #5 clk = ~clk;

  mux_arbiter #(.DATA_W(8), .MAX_BURST(4)) u_b4 (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2), .IN1(in1), .IN2(in2),
    .out_ready(out_ready), .gnt1(gnt1_o[0]), .gnt2(gnt2_o[0]), .sel(sel_o[0]),
    .out(out_o[0]), .out_valid(ov_o[0]), .ack1(ack1_o[0]), .ack2(ack2_o[0])
  );

  mux_arbiter #(.DATA_W(8), .MAX_BURST(1)) u_b1 (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2), .IN1(in1), .IN2(in2),
    .out_ready(out_ready), .gnt1(gnt1_o[1]), .gnt2(gnt2_o[1]), .sel(sel_o[1]),
    .out(out_o[1]), .out_valid(ov_o[1]), .ack1(ack1_o[1]), .ack2(ack2_o[1])
  );

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s[burst=%0d] observed=%h expected=%h at %0t", tag, mb[k], obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = 0;
      m_cnt[k]   = 0;
      m_last[k]  = 2;
    end
  endtask

  // Apply inputs, check outputs mid-cycle, advance the model across the edge.
  task automatic step(input logic r, input logic a, input logic b, input logic rdy,
                      input logic [7:0] d1, input logic [7:0] d2);
    rst = r; req1 = a; req2 = b; out_ready = rdy; in1 = d1; in2 = d2;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic eg1, eg2, eov, ebeat, mine, other_r;
      int oth;
      eg1   = (m_owner[k] == 1);
      eg2   = (m_owner[k] == 2);
      eov   = (eg1 && a) || (eg2 && b);
      ebeat = eov && rdy;
      chk("gnt1", k, 8'(gnt1_o[k]), 8'(eg1));
      chk("gnt2", k, 8'(gnt2_o[k]), 8'(eg2));
      chk("sel", k, 8'(sel_o[k]), 8'(eg2));
      chk("out", k, out_o[k], eg2 ? d2 : d1);
      chk("out_valid", k, 8'(ov_o[k]), 8'(eov));
      chk("ack1", k, 8'(ack1_o[k]), 8'(ebeat && eg1));
      chk("ack2", k, 8'(ack2_o[k]), 8'(ebeat && eg2));

      if (r) begin
        m_owner[k] = 0; m_cnt[k] = 0; m_last[k] = 2;
      end else if (m_owner[k] == 0) begin
        if (a && (!b || m_last[k] == 2)) m_owner[k] = 1;
        else if (b) m_owner[k] = 2;
        if (m_owner[k] != 0) begin
          m_cnt[k]  = 0;
          m_last[k] = m_owner[k];
        end
      end else begin
        mine    = (m_owner[k] == 1) ? a : b;
        other_r = (m_owner[k] == 1) ? b : a;
        oth     = 3 - m_owner[k];
        if (!mine) begin
          m_cnt[k]   = 0;
          m_owner[k] = other_r ? oth : 0;
          if (m_owner[k] != 0) m_last[k] = m_owner[k];
        end else if (rdy) begin
          if (m_cnt[k] + 1 == mb[k]) begin
            m_cnt[k] = 0;
            if (other_r) begin
              m_owner[k] = oth;
              m_last[k]  = oth;
            end
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req1 = 1'b0; req2 = 1'b0; out_ready = 1'b0; in1 = 8'h00; in2 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset state held, then contention with bursts of 4 and 1
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 8'hB2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 8'hB2);
    chk("first_grant_latency", 0, 8'(gnt1_o[0]), 8'd1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 8'hB2);

    // only requester 2
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'(i), 8'(8'h40 + i));
    chk("req2_only_hold", 0, 8'(gnt2_o[0]), 8'd1);

    // stall mid-burst, then resume to burst end
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 8'h22);
    chk("stall_holds_gnt1", 0, 8'(gnt1_o[0]), 8'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22);

    // owner drop with and without a waiting requester
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 8'h44);
    chk("drop_switch_gnt2", 0, 8'(gnt2_o[0]), 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 8'h44);
    chk("drop_to_idle", 0, 8'(gnt2_o[0]), 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 8'h44);

    // reset mid-burst in GNT2, then tie goes to requester 1
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 8'h66);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 8'h66);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h66);
    chk("reset_clears_gnt2", 0, 8'(gnt2_o[0]), 8'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 8'h66);
    chk("tie_after_reset", 0, 8'(gnt1_o[0]), 8'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 8'h66);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 9) < 7),
           8'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
